// File: rtl/clock_time_core.sv
// Timekeeping and scan-timing core: 1 Hz prescaler, BCD hh:mm:ss counter with
// manual set modes, and the free-running 3-bit digit-scan index.
module clock_time_core #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] mode,
  input  logic       inc,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic [2:0] select,
  output logic       tick_1hz
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int SW = $clog2(SCAN_DIV);

  localparam logic [1:0] MODE_RUN      = 2'b00;
  localparam logic [1:0] MODE_SET_SEC  = 2'b01;
  localparam logic [1:0] MODE_SET_MIN  = 2'b10;
  localparam logic [1:0] MODE_SET_HOUR = 2'b11;

  localparam logic [PW-1:0] PSC_LAST  = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [PW-1:0] psc;
  logic [SW-1:0] spsc;
  logic          count_evt;

  // Wraps at the field maximum given as tens/ones digits; ones roll 9->0 otherwise.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                         input logic [3:0] tmax,
                                         input logic [3:0] omax);
    if (v[7:4] == tmax && v[3:0] == omax) return 8'h00;
    else if (v[3:0] == 4'd9)              return {v[7:4] + 4'd1, 4'd0};
    else                                  return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    count_evt = (mode == MODE_RUN) && run && (psc == PSC_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (mode != MODE_RUN) begin
      psc <= '0;
    end else if (run) begin
      psc <= count_evt ? '0 : psc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour     <= '0;
      minute   <= '0;
      second   <= '0;
      tick_1hz <= 1'b0;
    end else begin
      tick_1hz <= count_evt;
      if (count_evt) begin
        second <= bcd_inc(second, 4'd5, 4'd9);
        if (second == 8'h59) begin
          minute <= bcd_inc(minute, 4'd5, 4'd9);
          if (minute == 8'h59) hour <= bcd_inc(hour, 4'd2, 4'd3);
        end
      end else if (inc) begin
        // Set-mode increments touch one field only; no carry.
        case (mode)
          MODE_SET_SEC:  second <= bcd_inc(second, 4'd5, 4'd9);
          MODE_SET_MIN:  minute <= bcd_inc(minute, 4'd5, 4'd9);
          MODE_SET_HOUR: hour   <= bcd_inc(hour, 4'd2, 4'd3);
          default:       ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spsc   <= '0;
      select <= '0;
    end else if (spsc == SCAN_LAST) begin
      spsc   <= '0;
      select <= select + 1'b1;
    end else begin
      spsc <= spsc + 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_time_core.sv
// Directed bench for clock_time_core with CLK_HZ=10, SCAN_DIV=4; inputs are
// driven and outputs sampled on the falling clock edge.
module tb_clock_time_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [1:0] mode;
  logic       inc;
  logic [7:0] hour, minute, second;
  logic [2:0] select;
  logic       tick_1hz;

  int checks = 0;
  int errors = 0;

  clock_time_core #(.CLK_HZ(10), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .inc(inc),
    .hour(hour), .minute(minute), .second(second), .select(select),
    .tick_1hz(tick_1hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s);
    chk({tag, "_hour"}, {24'd0, hour}, {24'd0, h});
    chk({tag, "_min"},  {24'd0, minute}, {24'd0, m});
    chk({tag, "_sec"},  {24'd0, second}, {24'd0, s});
  endtask

  initial begin
    int ticks;
    logic [7:0] hexp [3];
    hexp[0] = 8'h23; hexp[1] = 8'h00; hexp[2] = 8'h01;

    rst_n = 1'b0; run = 1'b1; mode = 2'b00; inc = 1'b0;
    cyc(3);
    chk_time("rst0", 8'h00, 8'h00, 8'h00);
    chk("rst0_sel", {29'd0, select}, 32'd0);
    chk("rst0_tick", {31'd0, tick_1hz}, 32'd0);
    rst_n = 1'b1;

    // Scan sequence and first tick after reset release.
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      chk("scan_sel", {29'd0, select}, 32'((k / 4) % 8));
      if (k == 9)  chk("rel_tick9", {31'd0, tick_1hz}, 32'd0);
      if (k == 10) begin
        chk("rel_tick10", {31'd0, tick_1hz}, 32'd1);
        chk("rel_sec10", {24'd0, second}, 32'h01);
      end
      if (k == 11) chk("rel_tick11", {31'd0, tick_1hz}, 32'd0);
      if (k == 20) begin
        chk("rel_tick20", {31'd0, tick_1hz}, 32'd1);
        chk("rel_sec20", {24'd0, second}, 32'h02);
      end
      if (k >= 26) begin
        mode = 2'(k);
        run  = 1'(k % 2);
      end
    end
    chk("scan_sec_hold", {24'd0, second}, 32'h02);

    mode = 2'b00; run = 1'b1;
    cyc(13);
    chk("mid_sec", {24'd0, second}, 32'h03);
    chk("mid_sel", {29'd0, select}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk_time("async_rst", 8'h00, 8'h00, 8'h00);
    chk("async_rst_sel", {29'd0, select}, 32'd0);
    chk("async_rst_tick", {31'd0, tick_1hz}, 32'd0);
    cyc(1);

    // Set 23:59:58, then run through midnight.
    rst_n = 1'b1; mode = 2'b11; inc = 1'b1;
    cyc(23);
    mode = 2'b10; cyc(59);
    mode = 2'b01; cyc(58);
    inc = 1'b0;
    chk_time("set_235958", 8'h23, 8'h59, 8'h58);
    mode = 2'b00;
    cyc(10);
    chk_time("roll_a", 8'h23, 8'h59, 8'h59);
    chk("roll_a_tick", {31'd0, tick_1hz}, 32'd1);
    cyc(9);
    chk_time("roll_b", 8'h23, 8'h59, 8'h59);
    cyc(1);
    chk_time("roll_mid", 8'h00, 8'h00, 8'h00);
    chk("roll_mid_tick", {31'd0, tick_1hz}, 32'd1);

    // 09:59:59 -> 10:00:00
    mode = 2'b11; inc = 1'b1; cyc(9);
    mode = 2'b10; cyc(59);
    mode = 2'b01; cyc(59);
    inc = 1'b0; mode = 2'b00;
    cyc(9);
    chk_time("roll9_pre", 8'h09, 8'h59, 8'h59);
    chk("roll9_pre_tick", {31'd0, tick_1hz}, 32'd0);
    cyc(1);
    chk_time("roll10", 8'h10, 8'h00, 8'h00);
    chk("roll10_tick", {31'd0, tick_1hz}, 32'd1);

    // Pause at prescaler 6.
    cyc(6);
    run = 1'b0;
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (tick_1hz) ticks++;
    end
    chk("pause_ticks", 32'(ticks), 32'd0);
    chk("pause_sec", {24'd0, second}, 32'h00);
    run = 1'b1;
    cyc(3);
    chk("resume_tick3", {31'd0, tick_1hz}, 32'd0);
    cyc(1);
    chk("resume_tick4", {31'd0, tick_1hz}, 32'd1);
    chk("resume_sec", {24'd0, second}, 32'h01);

    // Hour set wrap 22 -> 23 -> 00 -> 01.
    mode = 2'b11; inc = 1'b1; cyc(12); inc = 1'b0;
    chk("set_h22", {24'd0, hour}, 32'h22);
    for (int i = 0; i < 3; i++) begin
      inc = 1'b1; cyc(1); inc = 1'b0;
      chk("set_hwrap", {24'd0, hour}, {24'd0, hexp[i]});
      cyc(1);
    end
    chk("set_hwrap_min", {24'd0, minute}, 32'h00);
    chk("set_hwrap_sec", {24'd0, second}, 32'h01);

    mode = 2'b01; inc = 1'b1; cyc(58); inc = 1'b0;
    chk("set_s59", {24'd0, second}, 32'h59);
    inc = 1'b1; cyc(1); inc = 1'b0;
    chk_time("set_swrap", 8'h01, 8'h00, 8'h00);

    mode = 2'b00; run = 1'b0; inc = 1'b1; cyc(3); inc = 1'b0; cyc(1);
    chk_time("run_inc", 8'h01, 8'h00, 8'h00);

    // inc together with mode change, then SET exit timing.
    mode = 2'b10; inc = 1'b1; run = 1'b1;
    cyc(1); inc = 1'b0;
    chk("modechg_min", {24'd0, minute}, 32'h01);
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (tick_1hz) ticks++;
    end
    chk("set_noticks", 32'(ticks), 32'd0);
    mode = 2'b00;
    cyc(9);
    chk("exit_tick9", {31'd0, tick_1hz}, 32'd0);
    cyc(1);
    chk("exit_tick10", {31'd0, tick_1hz}, 32'd1);
    chk_time("exit_time", 8'h01, 8'h01, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_time_core.md
# clock_time_core

Timekeeping and scan-timing core of the digital clock. It divides the board clock into a 1 Hz tick and keeps a BCD hours:minutes:seconds count over 00:00:00–23:59:59. Manual set modes adjust each field. It also generates the free-running 3-bit digit-scan index. Its `hour`, `minute`, `second` and `select` outputs drive the 8-digit display selector stage directly downstream.

## Interface
- `CLK_HZ`, default 100_000_000: input clock cycles per 1 Hz tick (must be ≥ 2).
- `SCAN_DIV`, default 100_000: input clock cycles per scan-index advance (must be ≥ 2).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `run`  in  1  1 = timekeeping enabled in RUN mode; 0 = pause.
- `mode`  in  2  00 RUN, 01 SET_SEC, 10 SET_MIN, 11 SET_HOUR.
- `inc`  in  1  single-cycle, already-debounced increment pulse, used only in SET modes.
- `hour`  out  8  BCD hours, [7:4] tens 0–2, [3:0] ones 0–9.
- `minute`  out  8  BCD minutes, tens 0–5.
- `second`  out  8  BCD seconds, tens 0–5.
- `select`  out  3  digit-scan index 0–7.
- `tick_1hz`  out  1  one-cycle pulse, high in the cycle a counted second first appears on `second`.

## Operation
- **Reset (rst_n low, any time, asynchronous):**
  - `hour`, `minute` and `second` are 8'h00; `select` is 0; `tick_1hz` is 0.
  - Both prescalers are 0.
  - A reset mid-count or mid-set discards all state.
- **Second prescaler:**
  - Width is $clog2(CLK_HZ), range 0..CLK_HZ-1.
  - Advances only when `mode`==00 and `run`==1.
  - At CLK_HZ-1 it wraps to 0 and issues a count event.
  - RUN with `run`==0 holds its value, so a pause resumes mid-second.
  - Any SET mode clears it to 0 and holds it there.
- **Count event (RUN):**
  - `second` ones go 0–9; at 9 they wrap to 0 and tens increment.
  - At `second`==8'h59 it goes to 8'h00 and `minute` increments by the same rule.
  - At `minute`==8'h59 plus a carry, it goes to 8'h00 and `hour` increments.
  - `hour` ones wrap at 9 while tens < 2. At 8'h23 plus a carry, `hour` goes to 8'h00.
  - 23:59:59 → 00:00:00 happens on a single edge.
- **SET modes:**
  - No count events occur.
  - Each `inc` pulse increments only the selected field, with no carry into other fields.
  - `second` and `minute` wrap 59→00; `hour` wraps 23→00.
  - `inc` is ignored in RUN.
  - `inc` and a `mode` change in the same cycle act on the `mode` value sampled that cycle.
- **Leaving SET for RUN:** the prescaler starts from 0, so the first count event is CLK_HZ cycles after the first RUN cycle with `run`==1.
- **Scan counter:**
  - The prescaler is 0..SCAN_DIV-1.
  - On wrap, `select` increments modulo 8 (7→0).
  - It is free-running and independent of `mode` and `run`.
- **Value rule:** fields are never non-BCD. Values outside 00–59 (min/sec) or 00–23 (hour) are unreachable.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- **Count latency:** the edge at which the prescaler is CLK_HZ-1 updates the time fields and sets `tick_1hz`=1 for exactly the next cycle.
- In continuous RUN the tick period is exactly CLK_HZ cycles.
- **inc latency:** the field update is visible the cycle after the `inc` edge.
- An `inc` held high N cycles gives N increments; debouncing is upstream.
- **select:** the period per index is exactly SCAN_DIV cycles, and the full 8-digit frame is 8×SCAN_DIV cycles.
- **Reset release:** first `select` change SCAN_DIV cycles after the first clk edge with `rst_n` high.
- With `run` held high, the first tick comes CLK_HZ cycles after the first such edge.

## Test plan
All scenarios run with CLK_HZ=10 and SCAN_DIV=4.
- **Reset:**
  - Stimulus: assert `rst_n` low mid-count.
  - Response: outputs become 00/00/00, `select`=0 and `tick_1hz`=0 immediately, without waiting for a clk edge.
  - After release with RUN and `run`=1, `second`=8'h01 with `tick_1hz`=1 exactly 10 cycles later.
- **Rollover:**
  - Stimulus: set 23:59:58 via SET modes, then RUN.
  - Response: after 2 ticks the time is 00:00:00 on one edge; separately, 09:59:59 → 10:00:00.
- **Pause:**
  - Stimulus: RUN, drop `run` at prescaler=6 for 50 cycles, then raise it.
  - Response: no tick during the pause; the next tick comes 4 cycles after resume.
- **Set wrap:**
  - Stimulus: SET_HOUR from 8'h22, 3 `inc` pulses.
  - Response: `hour` goes 23, 00, 01; `minute` and `second` unchanged.
  - Also: SET_SEC from 59 + `inc` gives 00 with `minute` unchanged; `inc` in RUN has no effect.
- **Set exit:**
  - Stimulus: return to RUN from SET_MIN.
  - Response: first tick exactly 10 cycles later; no tick in SET regardless of elapsed time.
- **Scan:**
  - Stimulus: 40 cycles from reset.
  - Response: `select` goes 0,1,…,7,0,1, each held 4 cycles, unaffected by `mode`/`run` toggling.
